// File: rtl/packed_pixel_bram_pkg.sv
// Shared defaults and layout mode encodings for the packed pixel frame buffer.
package packed_pixel_bram_pkg;
  localparam int PIX_W_DEF       = 8;
  localparam int LANES_DEF       = 4;
  localparam int DEPTH_DEF       = 2048;
  localparam int MODE_PLANAR     = 0;
  localparam int MODE_INTERLEAVE = 1;
endpackage

// File: rtl/packed_pixel_bram_bank.sv
// One pixel bank: simple dual-port RAM, synchronous read-first read with enable.
module packed_pixel_bram_bank #(
  parameter int W  = 8,
  parameter int D  = 512,
  localparam int IW = $clog2(D)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [D];
  logic [W-1:0] rdata_q;

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/packed_pixel_bram.sv
// Pixel frame buffer: streamed pixel writes, LANES pixels per packed read word.
module packed_pixel_bram
  import packed_pixel_bram_pkg::*;
#(
  parameter int PIX_W      = PIX_W_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int INTERLEAVE = MODE_PLANAR,
  localparam int AW = $clog2(DEPTH),
  localparam int RW = $clog2(DEPTH / LANES),
  localparam int LW = $clog2(LANES)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [PIX_W-1:0]       wr_data_i,
  input  logic                   wr_last_i,
  output logic                   frame_full_o,
  output logic [AW:0]            frame_len_o,
  input  logic                   frame_release_i,
  input  logic                   rd_req_i,
  output logic                   rd_req_ready_o,
  input  logic [RW-1:0]          rd_addr_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [LANES*PIX_W-1:0] rd_data_o
);
  // One extra pointer bit so a full-depth frame parks at DEPTH instead of wrapping.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] len_q, len_d;
  logic        full_q, full_d;
  logic        rvld_q, rvld_d;
  logic        wr_fire, rd_fire, frame_end;
  logic [LW-1:0] wr_bank;
  logic [RW-1:0] wr_idx;
  logic [LANES-1:0][PIX_W-1:0] lane_rd;

  assign wr_ready_o     = !full_q;
  assign rd_req_ready_o = !rvld_q || rd_ready_i;
  assign wr_fire        = wr_valid_i && wr_ready_o;
  assign rd_fire        = rd_req_i && rd_req_ready_o;
  assign frame_end      = wr_last_i || (wr_ptr_q == (AW+1)'(DEPTH - 1));

  generate
    if (INTERLEAVE == MODE_INTERLEAVE) begin : g_il
      assign wr_bank = wr_ptr_q[LW-1:0];
      assign wr_idx  = wr_ptr_q[AW-1:LW];
    end else begin : g_pl
      assign wr_bank = wr_ptr_q[AW-1 -: LW];
      assign wr_idx  = wr_ptr_q[RW-1:0];
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    full_d   = full_q;
    rvld_d   = rvld_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (frame_end) begin
        full_d = 1'b1;
        len_d  = wr_ptr_q + (AW+1)'(1);
      end
    end
    if (full_q && frame_release_i) begin
      full_d   = 1'b0;
      wr_ptr_d = '0;
    end
    if (rd_fire)         rvld_d = 1'b1;
    else if (rd_ready_i) rvld_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      len_q    <= '0;
      full_q   <= 1'b0;
      rvld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      full_q   <= full_d;
      rvld_q   <= rvld_d;
    end
  end

  // Read enable follows the accepted request, so a stalled word is never overwritten.
  for (genvar k = 0; k < LANES; k++) begin : g_bank
    packed_pixel_bram_bank #(.W(PIX_W), .D(DEPTH / LANES)) u_bank (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .we_i    (wr_fire && (wr_bank == LW'(k))),
      .waddr_i (wr_idx),
      .wdata_i (wr_data_i),
      .re_i    (rd_fire),
      .raddr_i (rd_addr_i),
      .rdata_o (lane_rd[k])
    );
  end

  assign frame_full_o = full_q;
  assign frame_len_o  = len_q;
  assign rd_valid_o   = rvld_q;
  assign rd_data_o    = lane_rd;
endmodule

// File: tb/tb_packed_pixel_bram.sv
// Directed bench: planar and interleaved instances share one stimulus stream.
module tb_packed_pixel_bram;
  logic clk = 1'b0;
  logic rst_n, wr_valid, wr_last, frame_release, rd_req, rd_ready;
  logic [7:0]  wr_data;
  logic [8:0]  rd_addr;
  logic        pl_wr_ready, pl_full, pl_rqr, pl_rvld;
  logic        il_wr_ready, il_full, il_rqr, il_rvld;
  logic [11:0] pl_len, il_len;
  logic [31:0] pl_rdata, il_rdata;
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  packed_pixel_bram #(.INTERLEAVE(0)) u_pl (
    .clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(pl_wr_ready),
    .wr_data_i(wr_data), .wr_last_i(wr_last), .frame_full_o(pl_full), .frame_len_o(pl_len),
    .frame_release_i(frame_release), .rd_req_i(rd_req), .rd_req_ready_o(pl_rqr),
    .rd_addr_i(rd_addr), .rd_valid_o(pl_rvld), .rd_ready_i(rd_ready), .rd_data_o(pl_rdata));

  packed_pixel_bram #(.INTERLEAVE(1)) u_il (
    .clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(il_wr_ready),
    .wr_data_i(wr_data), .wr_last_i(wr_last), .frame_full_o(il_full), .frame_len_o(il_len),
    .frame_release_i(frame_release), .rd_req_i(rd_req), .rd_req_ready_o(il_rqr),
    .rd_addr_i(rd_addr), .rd_valid_o(il_rvld), .rd_ready_i(rd_ready), .rd_data_o(il_rdata));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b1; wr_data = 8'hFF; wr_last = 1'b0;
    frame_release = 1'b0; rd_req = 1'b1; rd_addr = '0; rd_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rvld", pl_rvld, 0);
    chk("rst_rdata", pl_rdata, 0);
    chk("rst_full", pl_full, 0);
    chk("rst_wrdy", pl_wr_ready, 1);
    chk("rst_il_rdata", il_rdata, 0);
    chk("rst_len", pl_len, 0);
    wr_valid = 1'b0; rd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_rvld", pl_rvld, 0);

    // Full 2048-pixel frame, pixel i = i[7:0]
    for (int i = 0; i < 2047; i++) wr(8'(i), 1'b0);
    chk("full_before_last", pl_full, 0);
    wr(8'hFF, 1'b0);
    chk("full_set", pl_full, 1);
    chk("full_len", pl_len, 12'd2048);
    chk("full_wrdy", pl_wr_ready, 0);
    chk("il_full_len", il_len, 12'd2048);
    rd(9'd5);
    chk("pl_rd5_vld", pl_rvld, 1);
    chk("pl_rd5", pl_rdata, 32'h05050505);
    chk("il_rd5", il_rdata, 32'h17161514);
    rd(9'd3);
    chk("pl_rd3", pl_rdata, 32'h03030303);
    chk("il_rd3", il_rdata, 32'h0F0E0D0C);
    tick();
    chk("rvld_drop", pl_rvld, 0);
    frame_release = 1'b1; tick(); frame_release = 1'b0;
    chk("rel_full", pl_full, 0);
    chk("rel_len_hold", pl_len, 12'd2048);

    // Short frame of 100 pixels, value 0x40+i
    for (int i = 0; i < 100; i++) wr(8'h40 + 8'(i), i == 99);
    chk("short_full", pl_full, 1);
    chk("short_len", pl_len, 12'd100);
    chk("short_wrdy", pl_wr_ready, 0);
    wr(8'hEE, 1'b0);
    chk("extra_len", pl_len, 12'd100);
    wr_valid = 1'b1; wr_data = 8'hDD; frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    chk("rel2_wrdy", pl_wr_ready, 1);
    wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    rd(9'd100);
    chk("pl_no_extra", pl_rdata, 32'h64646464);
    rd(9'd25);
    chk("il_no_extra", il_rdata, 32'h67666564);

    // Back-to-back reads 0,1,2 with a 3-cycle stall on word 1
    rd_req = 1'b1; rd_addr = 9'd0;
    tick();
    chk("pl_w0", pl_rdata, 32'h00000077);
    chk("il_w0", il_rdata, 32'h43424177);
    rd_addr = 9'd1;
    tick();
    rd_ready = 1'b0; rd_addr = 9'd2;
    #1;
    chk("pl_w1", pl_rdata, 32'h01010141);
    chk("stall_rqr", pl_rqr, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_vld", pl_rvld, 1);
      chk("stall_pl_w1", pl_rdata, 32'h01010141);
      chk("stall_il_w1", il_rdata, 32'h47464544);
      chk("stall_rqr", pl_rqr, 0);
    end
    rd_ready = 1'b1;
    #1;
    chk("unstall_rqr", pl_rqr, 1);
    tick();
    rd_req = 1'b0;
    chk("pl_w2", pl_rdata, 32'h02020242);
    chk("il_w2", il_rdata, 32'h4B4A4948);
    chk("w2_vld", pl_rvld, 1);
    tick();
    chk("w2_drop", pl_rvld, 0);

    // Read-first collision at location 5 (wr_ptr is 1 here)
    for (int i = 1; i < 5; i++) wr(8'h10 + 8'(i), 1'b0);
    wr(8'hAA, 1'b1);
    chk("col_len", pl_len, 12'd6);
    frame_release = 1'b1; tick(); frame_release = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1'b0);
    wr_valid = 1'b1; wr_data = 8'h55; rd_req = 1'b1; rd_addr = 9'd5;
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("col_old", pl_rdata, 32'h050505AA);
    rd(9'd5);
    chk("col_new", pl_rdata, 32'h05050555);
    rd(9'd0);
    chk("col_w0", pl_rdata, 32'h00000020);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
